// File: rtl/vp_pred_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vp_pkg
// Purpose  : Shared types for the value-prediction alignment pipeline.
//            pred_lane_t is one lane of one pipeline stage. conf is already
//            reduced to a single confident bit at capture time.
// Revision : 1.0 - initial release
// ============================================================================
package vp_pkg;

  localparam int VP_PC_W = 31;

  typedef struct packed {
    logic [VP_PC_W:1] pc;
    logic [31:0]      result;
    logic             conf;
    logic             valid;
  } pred_lane_t;

endpackage
`default_nettype wire

// File: rtl/vp_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : vp_pipe_stage
// Purpose  : One lane-vector register stage of the prediction pipeline.
//            Loads d when not stalled, holds when stalled, and clears every
//            valid bit on flush (flush beats stall).
//            With VP_PRED_BYPASS_EN defined, each valid lane of the entry
//            that will occupy this stage after the edge is compared against
//            all mispredict feedback lanes; on a pc match the result is
//            replaced by the actual value and conf is cleared.
// Ports    : clk, rst (async, active-high), stall, flush
//            d      - lane vector from the previous stage (or capture)
//            fb_*   - mispredict feedback, one entry per lane
//            q      - registered lane vector
// Revision : 1.0 - initial release
// ============================================================================
import vp_pkg::*;

module vp_pipe_stage #(
  parameter int P_NUM_PRED = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic                              flush,
  input  pred_lane_t [P_NUM_PRED-1:0]       d,
  input  logic [P_NUM_PRED-1:0][VP_PC_W:1]  fb_pc,
  input  logic [P_NUM_PRED-1:0][31:0]       fb_actual,
  input  logic [P_NUM_PRED-1:0]             fb_mispredict,
  input  logic [P_NUM_PRED-1:0]             fb_valid,
  output pred_lane_t [P_NUM_PRED-1:0]       q
);

  pred_lane_t [P_NUM_PRED-1:0] nxt;

  always_comb begin
    // Bypass acts on whatever this stage will hold after the edge, so a held
    // entry is corrected during a stall and an advancing entry is corrected
    // on its way in.
    nxt = stall ? q : d;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      if (flush) begin
        nxt[i].valid = 1'b0;
      end
`ifdef VP_PRED_BYPASS_EN
      else if (nxt[i].valid) begin
        // Ascending scan: the last (highest-index) matching feedback lane wins.
        for (int j = 0; j < P_NUM_PRED; j++) begin
          if (fb_valid[j] && fb_mispredict[j] && (fb_pc[j] == nxt[i].pc)) begin
            nxt[i].result = fb_actual[j];
            nxt[i].conf   = 1'b0;
          end
        end
      end
`endif
    end
  end

`ifndef VP_PRED_BYPASS_EN
  // Feedback is not consumed in this build; fold it into a sink.
  logic unused_fb;
  assign unused_fb = ^{fb_pc, fb_actual, fb_mispredict, fb_valid};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vp_pred_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vp_pred_pipe
// Purpose  : Multi-lane prediction alignment pipeline between a value
//            predictor and decode/execute. Captures F2 predictions, reduces
//            the confidence counter to a confident bit, carries entries
//            through P_DEPTH stages under stall/flush, and presents them at
//            D (stage 1) and E1 (stage P_DEPTH). Counts confident predictions
//            consumed at E1 per lane with saturating counters.
// Config   : VP_PRED_BYPASS_EN - enables mispredict feedback bypass in every
//            stage; when undefined the feedback ports are ignored.
// Ports    : clk_i, rst_i (async, active-high)
//            in_pc_i/in_result_i/in_conf_i/in_valid_i - F2 predictions
//            stall_i, flush_i                         - pipeline control
//            en_e1_i                                  - E1 valid gate
//            fb_pc_i/fb_actual_i/fb_mispredict_i/fb_valid_i - feedback
//            stat_clr_i                               - clear usage counters
//            pred_*_d_o, pred_*_e1_o                  - stage 1 / stage P_DEPTH
//            stat_used_o                              - usage counters
// Revision : 1.0 - initial release
// ============================================================================
import vp_pkg::*;

module vp_pred_pipe #(
  parameter int P_NUM_PRED   = 2,
  parameter int P_CONF_WIDTH = 8,
  parameter int P_CONF_THRES = 255,
  parameter int P_DEPTH      = 2,
  parameter int P_STAT_WIDTH = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [P_NUM_PRED-1:0][31:1]            in_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]            in_result_i,
  input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0] in_conf_i,
  input  logic [P_NUM_PRED-1:0]                  in_valid_i,
  input  logic                                   stall_i,
  input  logic                                   flush_i,
  input  logic [P_NUM_PRED-1:0]                  en_e1_i,
  input  logic [P_NUM_PRED-1:0][31:1]            fb_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]            fb_actual_i,
  input  logic [P_NUM_PRED-1:0]                  fb_mispredict_i,
  input  logic [P_NUM_PRED-1:0]                  fb_valid_i,
  input  logic                                   stat_clr_i,
  output logic [P_NUM_PRED-1:0][31:1]            pred_pc_d_o,
  output logic [P_NUM_PRED-1:0][31:0]            pred_result_d_o,
  output logic [P_NUM_PRED-1:0]                  pred_conf_d_o,
  output logic [P_NUM_PRED-1:0]                  pred_valid_d_o,
  output logic [P_NUM_PRED-1:0][31:1]            pred_pc_e1_o,
  output logic [P_NUM_PRED-1:0][31:0]            pred_result_e1_o,
  output logic [P_NUM_PRED-1:0]                  pred_conf_e1_o,
  output logic [P_NUM_PRED-1:0]                  pred_valid_e1_o,
  output logic [P_NUM_PRED-1:0][P_STAT_WIDTH-1:0] stat_used_o
);

  localparam logic [P_CONF_WIDTH-1:0] CONF_THRES = P_CONF_WIDTH'(P_CONF_THRES);

  pred_lane_t [P_NUM_PRED-1:0] cap;
  pred_lane_t [P_NUM_PRED-1:0] stg [1:P_DEPTH];
  logic [P_NUM_PRED-1:0]                   stat_inc;
  logic [P_NUM_PRED-1:0][P_STAT_WIDTH-1:0] stat_cnt;

  // Capture: reduce the wide confidence counter to a single bit.
  always_comb begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      cap[i].pc     = in_pc_i[i];
      cap[i].result = in_result_i[i];
      cap[i].conf   = (in_conf_i[i] >= CONF_THRES);
      cap[i].valid  = in_valid_i[i];
    end
  end

  for (genvar k = 1; k <= P_DEPTH; k++) begin : g_stage
    if (k == 1) begin : g_first
      vp_pipe_stage #(.P_NUM_PRED(P_NUM_PRED)) u_stage (
        .clk           (clk_i),
        .rst           (rst_i),
        .stall         (stall_i),
        .flush         (flush_i),
        .d             (cap),
        .fb_pc         (fb_pc_i),
        .fb_actual     (fb_actual_i),
        .fb_mispredict (fb_mispredict_i),
        .fb_valid      (fb_valid_i),
        .q             (stg[k])
      );
    end else begin : g_next
      vp_pipe_stage #(.P_NUM_PRED(P_NUM_PRED)) u_stage (
        .clk           (clk_i),
        .rst           (rst_i),
        .stall         (stall_i),
        .flush         (flush_i),
        .d             (stg[k-1]),
        .fb_pc         (fb_pc_i),
        .fb_actual     (fb_actual_i),
        .fb_mispredict (fb_mispredict_i),
        .fb_valid      (fb_valid_i),
        .q             (stg[k])
      );
    end
  end

  // E1 valid is gated combinationally by the per-lane enable so the consumer
  // can refuse a prediction in the same cycle.
  always_comb begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      pred_pc_d_o[i]      = stg[1][i].pc;
      pred_result_d_o[i]  = stg[1][i].result;
      pred_conf_d_o[i]    = stg[1][i].conf;
      pred_valid_d_o[i]   = stg[1][i].valid;
      pred_pc_e1_o[i]     = stg[P_DEPTH][i].pc;
      pred_result_e1_o[i] = stg[P_DEPTH][i].result;
      pred_conf_e1_o[i]   = stg[P_DEPTH][i].conf;
      pred_valid_e1_o[i]  = stg[P_DEPTH][i].valid & en_e1_i[i];
      stat_inc[i]         = stg[P_DEPTH][i].valid & en_e1_i[i]
                          & stg[P_DEPTH][i].conf & ~stall_i;
    end
  end

  // Saturating usage counters; clear beats increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < P_NUM_PRED; i++) begin
        if (stat_clr_i) begin
          stat_cnt[i] <= '0;
        end else if (stat_inc[i] && (stat_cnt[i] != '1)) begin
          stat_cnt[i] <= stat_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign stat_used_o = stat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vp_pred_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vp_pred_pipe
// Purpose  : Self-checking bench for vp_pred_pipe (2 lanes, depth 2, 4-bit
//            usage counters). Directed table, hand-written corner sequences
//            and a randomized phase against an entry-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vp_pred_pipe;

  localparam int NP    = 2;
  localparam int CW    = 8;
  localparam int TH    = 255;
  localparam int DEPTH = 2;
  localparam int SW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0][31:1]   in_pc;
  logic [NP-1:0][31:0]   in_result;
  logic [NP-1:0][CW-1:0] in_conf;
  logic [NP-1:0]         in_valid;
  logic                  stall, flush;
  logic [NP-1:0]         en_e1;
  logic [NP-1:0][31:1]   fb_pc;
  logic [NP-1:0][31:0]   fb_actual;
  logic [NP-1:0]         fb_mis, fb_valid;
  logic                  stat_clr;
  logic [NP-1:0][31:1]   pc_d, pc_e1;
  logic [NP-1:0][31:0]   res_d, res_e1;
  logic [NP-1:0]         conf_d, valid_d, conf_e1, valid_e1;
  logic [NP-1:0][SW-1:0] stat_used;

  vp_pred_pipe #(
    .P_NUM_PRED(NP), .P_CONF_WIDTH(CW), .P_CONF_THRES(TH),
    .P_DEPTH(DEPTH), .P_STAT_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_pc_i(in_pc), .in_result_i(in_result), .in_conf_i(in_conf), .in_valid_i(in_valid),
    .stall_i(stall), .flush_i(flush), .en_e1_i(en_e1),
    .fb_pc_i(fb_pc), .fb_actual_i(fb_actual), .fb_mispredict_i(fb_mis), .fb_valid_i(fb_valid),
    .stat_clr_i(stat_clr),
    .pred_pc_d_o(pc_d), .pred_result_d_o(res_d), .pred_conf_d_o(conf_d), .pred_valid_d_o(valid_d),
    .pred_pc_e1_o(pc_e1), .pred_result_e1_o(res_e1), .pred_conf_e1_o(conf_e1), .pred_valid_e1_o(valid_e1),
    .stat_used_o(stat_used)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane keeps the list of entries accepted into the pipeline; the newest
  // is at D and the one accepted DEPTH-1 advances earlier is at E1.
  typedef struct {
    logic [31:1] pc;
    logic [31:0] res;
    logic        conf;
    logic        valid;
  } ent_t;

  ent_t hist [NP][$];
  int   cnt  [NP];

  function automatic void model_reset();
    ent_t z;
    z.pc = '0; z.res = '0; z.conf = 1'b0; z.valid = 1'b0;
    for (int l = 0; l < NP; l++) begin
      hist[l].delete();
      for (int k = 0; k < DEPTH; k++) hist[l].push_back(z);
      cnt[l] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int l = 0; l < NP; l++) begin
      ent_t e1, n, t;
      e1 = hist[l][0];
      if (stat_clr) cnt[l] = 0;
      else if (e1.valid && e1.conf && en_e1[l] && !stall && cnt[l] < (1 << SW) - 1) cnt[l]++;
      if (flush)
        for (int k = 0; k < DEPTH; k++) begin
          t = hist[l][k]; t.valid = 1'b0; hist[l][k] = t;
        end
      if (!stall) begin
        n.pc = in_pc[l]; n.res = in_result[l];
        n.conf = (int'(in_conf[l]) >= TH);
        n.valid = in_valid[l] && !flush;
        hist[l].push_back(n);
        void'(hist[l].pop_front());
      end
`ifdef VP_PRED_BYPASS_EN
      if (!flush)
        for (int k = 0; k < DEPTH; k++) begin
          t = hist[l][k];
          if (t.valid)
            for (int j = 0; j < NP; j++)
              if (fb_valid[j] && fb_mis[j] && fb_pc[j] == t.pc) begin
                t.res = fb_actual[j]; t.conf = 1'b0;
              end
          hist[l][k] = t;
        end
`endif
    end
  endfunction

  task automatic model_check();
    for (int l = 0; l < NP; l++) begin
      ent_t d, e;
      d = hist[l][DEPTH-1];
      e = hist[l][0];
      check($sformatf("d_valid[%0d]", l), 64'(valid_d[l]), 64'(d.valid));
      if (d.valid) begin
        check($sformatf("d_pc[%0d]", l), 64'(pc_d[l]), 64'(d.pc));
        check($sformatf("d_res[%0d]", l), 64'(res_d[l]), 64'(d.res));
        check($sformatf("d_conf[%0d]", l), 64'(conf_d[l]), 64'(d.conf));
      end
      check($sformatf("e1_valid[%0d]", l), 64'(valid_e1[l]), 64'(e.valid & en_e1[l]));
      if (e.valid) begin
        check($sformatf("e1_pc[%0d]", l), 64'(pc_e1[l]), 64'(e.pc));
        check($sformatf("e1_res[%0d]", l), 64'(res_e1[l]), 64'(e.res));
        check($sformatf("e1_conf[%0d]", l), 64'(conf_e1[l]), 64'(e.conf));
      end
      check($sformatf("stat[%0d]", l), 64'(stat_used[l]), 64'(cnt[l]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    model_check();
  endtask

  task automatic idle();
    in_pc = '0; in_result = '0; in_conf = '0; in_valid = '0;
    stall = 1'b0; flush = 1'b0; en_e1 = '1; stat_clr = 1'b0;
    fb_pc = '0; fb_actual = '0; fb_mis = '0; fb_valid = '0;
  endtask

  task automatic lane0(input logic [31:1] pc, input logic [31:0] res, input logic [7:0] cf);
    in_valid[0] = 1'b1; in_pc[0] = pc; in_result[0] = res; in_conf[0] = cf;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_d"}, 64'(valid_d), 64'(0));
    check({tag, "_valid_e1"}, 64'(valid_e1), 64'(0));
    check({tag, "_pc_d"}, 64'(pc_d), 64'(0));
    check({tag, "_res_d"}, 64'(res_d), 64'(0));
    check({tag, "_conf_d"}, 64'(conf_d), 64'(0));
    check({tag, "_pc_e1"}, 64'(pc_e1), 64'(0));
    check({tag, "_res_e1"}, 64'(res_e1), 64'(0));
    check({tag, "_conf_e1"}, 64'(conf_e1), 64'(0));
    check({tag, "_stat"}, 64'(stat_used), 64'(0));
  endtask

  // ---------------- directed table (lane 0) ----------------
  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [7:0]  conf;
    logic        stall;
    logic        flush;
    logic        exp_dv;
    logic [31:0] exp_dres;
    logic        exp_ev;
    logic [31:0] exp_eres;
    logic        exp_econf;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int first_k, seen;
    logic [31:0] exp_res;
    logic        exp_conf;

    tbl[0] = '{1'b1, 32'hDEADBEEF, 8'd255, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 32'h11111111, 8'd254, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0};
    tbl[3] = '{1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[4] = '{1'b1, 32'h0000A5A5, 8'd200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 32'h0000A5A5, 8'd255, 1'b0, 1'b0, 1'b1, 32'h0000A5A5, 1'b0, 32'h0, 1'b0};
    tbl[6] = '{1'b1, 32'h00000077, 8'd255, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};

    // Reset state, observed while reset is still asserted.
    idle();
    model_reset();
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: latency, confidence threshold, stall hold, flush of capture.
    for (int r = 0; r < 8; r++) begin
      idle();
      if (tbl[r].valid) lane0(31'h1000, tbl[r].res, tbl[r].conf);
      stall = tbl[r].stall;
      flush = tbl[r].flush;
      step();
      check($sformatf("tbl%0d_dv", r), 64'(valid_d[0]), 64'(tbl[r].exp_dv));
      if (tbl[r].exp_dv) check($sformatf("tbl%0d_dres", r), 64'(res_d[0]), 64'(tbl[r].exp_dres));
      check($sformatf("tbl%0d_ev", r), 64'(valid_e1[0]), 64'(tbl[r].exp_ev));
      if (tbl[r].exp_ev) begin
        check($sformatf("tbl%0d_eres", r), 64'(res_e1[0]), 64'(tbl[r].exp_eres));
        check($sformatf("tbl%0d_econf", r), 64'(conf_e1[0]), 64'(tbl[r].exp_econf));
      end
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      idle();
      lane0(31'h100 + 31'(i), 32'hB0 + 32'(i), 8'd255);
      step();
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stall of 3 cycles while an entry sits at D.
    idle();
    lane0(31'h3000, 32'hCAFE0001, 8'd255);
    step();
    idle();
    first_k = -1;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      stall = (k <= 3);
      step();
      if (valid_e1[0] && res_e1[0] == 32'hCAFE0001) begin
        if (first_k < 0) first_k = k;
        seen++;
      end
    end
    check("stall_e1_edge", 64'(first_k), 64'(4));
    check("stall_e1_once", 64'(seen), 64'(1));

    // Flush during stall, then a fresh entry.
    idle(); lane0(31'h10, 32'hA0, 8'd255); step();
    idle(); lane0(31'h11, 32'hB0, 8'd255); step();
    check("fs_pre_e1", 64'(valid_e1[0]), 64'(1));
    idle(); lane0(31'h12, 32'hC0, 8'd255); stall = 1'b1; flush = 1'b1; step();
    check("fs_valid_d", 64'(valid_d), 64'(0));
    check("fs_valid_e1", 64'(valid_e1), 64'(0));
    idle(); lane0(31'h13, 32'h4E, 8'd255); step();
    check("fs_new_d", 64'(valid_d[0]), 64'(1));
    idle(); step();
    check("fs_new_e1_v", 64'(valid_e1[0]), 64'(1));
    check("fs_new_e1_r", 64'(res_e1[0]), 64'(32'h4E));

    // Bypass: two feedback lanes match, lane 1 must win.
    idle(); lane0(31'h2000, 32'h1234, 8'd255); step();
    idle();
    fb_valid = 2'b11; fb_mis = 2'b11;
    fb_pc[0] = 31'h2000; fb_pc[1] = 31'h2000;
    fb_actual[0] = 32'h66; fb_actual[1] = 32'h55;
    step();
`ifdef VP_PRED_BYPASS_EN
    exp_res = 32'h55; exp_conf = 1'b0;
`else
    exp_res = 32'h1234; exp_conf = 1'b1;
`endif
    check("byp_e1_v", 64'(valid_e1[0]), 64'(1));
    check("byp_e1_res", 64'(res_e1[0]), 64'(exp_res));
    check("byp_e1_conf", 64'(conf_e1[0]), 64'(exp_conf));

    // Usage counter saturation, enable gating, clear.
    idle(); stat_clr = 1'b1; step();
    for (int i = 0; i < 20; i++) begin
      idle();
      en_e1 = 2'b01;
      lane0(31'h40 + 31'(i), 32'(i), 8'd255);
      in_valid[1] = 1'b1; in_pc[1] = 31'h80; in_result[1] = 32'(i); in_conf[1] = 8'd255;
      step();
      check("cnt_gate_e1v1", 64'(valid_e1[1]), 64'(0));
    end
    idle(); en_e1 = 2'b01; step(); step();
    check("cnt_sat0", 64'(stat_used[0]), 64'(15));
    check("cnt_gated1", 64'(stat_used[1]), 64'(0));
    idle(); stat_clr = 1'b1; step();
    check("cnt_clr0", 64'(stat_used[0]), 64'(0));

    // Randomized phase against the model.
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < NP; l++) begin
        int sel;
        in_valid[l]  = ($urandom_range(0, 3) != 0);
        in_pc[l]     = 31'($urandom_range(0, 7));
        in_result[l] = $urandom;
        sel = int'($urandom_range(0, 3));
        in_conf[l]   = (sel == 1) ? 8'd254 : (sel == 2) ? 8'($urandom) : 8'd255;
        fb_pc[l]     = 31'($urandom_range(0, 7));
        fb_actual[l] = $urandom;
      end
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      stat_clr = ($urandom_range(0, 29) == 0);
      en_e1    = NP'($urandom);
      fb_valid = NP'($urandom);
      fb_mis   = NP'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
